gcd_engine: RTL

Sequential, parametrised GCD unit that computes the greatest common divisor of two unsigned XLEN-bit operands.
- Mode is selected per transaction: classic subtractive Euclid (one compare-and-subtract step per cycle) or binary Stein (shift/subtract step per cycle).
- Valid/ready handshakes on input and output.
- Reports the iteration count alongside the result.
- Sits in the gcd datapath as the iterating engine, replacing the standalone single-step subtract stage.

---
 rtl/gcd_pkg.sv | 21 ++
 rtl/gcd_step.sv | 64 ++++++
 rtl/gcd_engine.sv | 110 +++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared types for the GCD engine: FSM states, per-transaction mode, shift-count width.
// No logic; imported by gcd_step and gcd_engine.
package gcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic {
      MODE_SUB = 1'b0,
      MODE_BIN = 1'b1
   } mode_e;

   // Common power-of-two shift k never exceeds XLEN-1, so XLEN+1 codes are plenty.
   function automatic int k_width(input int xlen);
      return $clog2(xlen + 1);
   endfunction

endpackage

// File: rtl/gcd_step.sv
// One combinational GCD iteration (subtractive or Stein) plus termination detect.
// Zero latency; no handshake, the engine decides when the step result is committed.
module gcd_step
   import gcd_pkg::*;
#(
   parameter int XLEN = 16,
   parameter int KW   = 5
) (
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   input  logic [KW-1:0]   i_k,
   input  mode_e           i_mode,
   output logic [XLEN-1:0] o_a,
   output logic [XLEN-1:0] o_b,
   output logic [KW-1:0]   o_k,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);

   logic [XLEN:0]   w_diff;
   logic            w_a_lt_b;
   logic [XLEN-1:0] w_abs;
   logic [XLEN-1:0] w_min;

   // Extra top bit of the difference is the borrow: it picks both |A-B| and min(A,B).
   assign w_diff   = {1'b0, i_a} - {1'b0, i_b};
   assign w_a_lt_b = w_diff[XLEN];
   assign w_abs    = w_a_lt_b ? (~w_diff[XLEN-1:0] + {{(XLEN-1){1'b0}}, 1'b1})
                              : w_diff[XLEN-1:0];
   assign w_min    = w_a_lt_b ? i_a : i_b;

   always_comb begin
      o_a      = i_a;
      o_b      = i_b;
      o_k      = i_k;
      o_done   = 1'b0;
      o_result = '0;
      if (i_a == '0) begin
         o_done   = 1'b1;
         o_result = i_b << i_k;
      end else if (i_b == '0) begin
         o_done   = 1'b1;
         o_result = i_a << i_k;
      end else if (i_mode == MODE_SUB) begin
         o_a = w_abs;
         o_b = w_min;
      end else begin
         case ({i_a[0], i_b[0]})
            2'b00: begin
               o_a = i_a >> 1;
               o_b = i_b >> 1;
               o_k = i_k + KW'(1);
            end
            2'b01:   o_a = i_a >> 1;
            2'b10:   o_b = i_b >> 1;
            default: begin
               o_a = w_abs;
               o_b = w_min;
            end
         endcase
      end
   end

endmodule

// File: rtl/gcd_engine.sv
// Iterating GCD engine, one step per cycle; result valid iters+1 cycles after accept.
// Accepts only when idle; holds gcd_o/iters_o in DONE until out_ready_i; flush_i aborts.
module gcd_engine
   import gcd_pkg::*;
#(
   parameter int XLEN   = 16,
   parameter int ITER_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [XLEN-1:0]   a_i,
   input  logic [XLEN-1:0]   b_i,
   input  logic              mode_i,
   input  logic              flush_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [XLEN-1:0]   gcd_o,
   output logic [ITER_W-1:0] iters_o
);

   localparam int KW = k_width(XLEN);

   state_e              r_state;
   state_e              w_state_nxt;
   logic [XLEN-1:0]     r_a;
   logic [XLEN-1:0]     r_b;
   logic [KW-1:0]       r_k;
   mode_e               r_mode;
   logic [ITER_W-1:0]   r_iters;
   logic [XLEN-1:0]     r_gcd;

   logic [XLEN-1:0]     w_a_nxt;
   logic [XLEN-1:0]     w_b_nxt;
   logic [KW-1:0]       w_k_nxt;
   logic                w_done;
   logic [XLEN-1:0]     w_result;

   gcd_step #(
      .XLEN (XLEN),
      .KW   (KW)
   ) u_step (
      .i_a      (r_a),
      .i_b      (r_b),
      .i_k      (r_k),
      .i_mode   (r_mode),
      .o_a      (w_a_nxt),
      .o_b      (w_b_nxt),
      .o_k      (w_k_nxt),
      .o_done   (w_done),
      .o_result (w_result)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (flush_i) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (in_valid_i)  w_state_nxt = CALC;
            CALC:    if (w_done)      w_state_nxt = DONE;
            DONE:    if (out_ready_i) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Flush freezes the datapath so gcd_o/iters_o keep whatever they last showed.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_a     <= '0;
         r_b     <= '0;
         r_k     <= '0;
         r_mode  <= MODE_SUB;
         r_iters <= '0;
         r_gcd   <= '0;
      end else if (!flush_i) begin
         case (r_state)
            IDLE: if (in_valid_i) begin
               r_a     <= a_i;
               r_b     <= b_i;
               r_k     <= '0;
               r_mode  <= mode_e'(mode_i);
               r_iters <= '0;
            end
            CALC: if (w_done) begin
               r_gcd <= w_result;
            end else begin
               r_a <= w_a_nxt;
               r_b <= w_b_nxt;
               r_k <= w_k_nxt;
               if (r_iters != '1) r_iters <= r_iters + ITER_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign in_ready_o  = (r_state == IDLE);
   assign out_valid_o = (r_state == DONE);
   assign gcd_o       = r_gcd;
   assign iters_o     = r_iters;

endmodule
